program_counter: RTL and testbench

// - Program counter for the SAP-2-mini CPU. Holds the address of the next instruction.
// - Increments on command, or loads a jump target from the shared 8-bit bus.
// - Drives its value onto the shared tri-state bus when enabled, for the memory address register.
// - Sits on the common bus alongside the other SAP-2-mini registers; the control sequencer drives lp/cp/ep.
//

---
 rtl/sap2_pkg.sv | 8 +
 rtl/tristate_driver.sv | 13 +
 rtl/program_counter.sv | 53 +++++
 tb/tb_program_counter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sap2_pkg.sv
// Shared constants for the SAP-2-mini register slice: bus width and the
// program counter reset value.
package sap2_pkg;

  localparam int BUS_W  = 8;
  localparam int PC_RST = 0;

endpackage : sap2_pkg

// File: rtl/tristate_driver.sv
// Enable-controlled WIDTH-bit driver onto a shared tri-state bus; releases
// the bus (high-Z) whenever en is low so other registers can drive it.
module tristate_driver #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  inout  wire  [WIDTH-1:0] bus_io
);

  assign bus_io = en ? data : {WIDTH{1'bz}};

endmodule : tristate_driver

// File: rtl/program_counter.sv
// SAP-2-mini program counter: loads a jump target from the shared bus or
// increments, and drives its value onto the bus for the memory address register.
module program_counter
  import sap2_pkg::*;
#(
  parameter int WIDTH = BUS_W
) (
  input  logic             clk,
  input  logic             clr,
  inout  wire  [WIDTH-1:0] bus,
  input  logic             lp,
  input  logic             cp,
  input  logic             ep,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic             drive_en;

  // Load has priority over count; increment wraps naturally at 2^WIDTH.
  always_comb begin
    // NOTE: default assignment first so every path assigns pc_d and no latch is inferred.
    pc_d = pc_q;
    if (lp) begin
      pc_d = bus;
    end else if (cp) begin
      pc_d = pc_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc_q <= WIDTH'(PC_RST);
    end else begin
      // NOTE: non-blocking assignment for state so every flop samples pre-edge values.
      pc_q <= pc_d;
    end
  end

  // A load means someone else owns the bus this cycle, so never drive it then.
  assign drive_en = ep && !lp;
  assign q        = pc_q;

  tristate_driver #(
    .WIDTH (WIDTH)
  ) u_bus_drv (
    .data   (pc_q),
    .en     (drive_en),
    .bus_io (bus)
  );

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: stimulus queues expected q/bus values,
// a monitor pops and compares them whenever an observation point is signalled.
module tb_program_counter;

  localparam int W = 8;

  logic         clk;
  logic         clr;
  logic         lp;
  logic         cp;
  logic         ep;
  logic [W-1:0] q;
  logic         tb_en;
  logic [W-1:0] tb_val;
  // Pulled high when nobody drives it, so a released bus reads 8'hFF.
  tri1  [W-1:0] bus;

  assign bus = tb_en ? tb_val : {W{1'bz}};

  program_counter #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus),
    .lp  (lp),
    .cp  (cp),
    .ep  (ep),
    .q   (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] exp_q;
    bit           chk_bus;
    logic [W-1:0] exp_bus;
  } exp_t;

  exp_t sb[$];
  event obs_ev;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every pending expectation when an observation point fires.
  initial begin
    exp_t e;
    forever begin
      @(obs_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".q"}, q, e.exp_q);
        if (e.chk_bus) check({e.name, ".bus"}, bus, e.exp_bus);
      end
    end
  end

  task automatic expect_pc(input string nm, input logic [W-1:0] eq,
                           input bit cb, input logic [W-1:0] eb);
    exp_t e;
    e.name = nm; e.exp_q = eq; e.chk_bus = cb; e.exp_bus = eb;
    sb.push_back(e);
    ->obs_ev;
    #1;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr = 1'b0; lp = 1'b0; cp = 1'b0; ep = 1'b0;
    tb_en = 1'b0; tb_val = '0;

    // Reset state, and ep during reset drives 0.
    #12;
    expect_pc("reset", 8'h00, 1'b1, 8'hFF);
    ep = 1'b1;
    #1;
    expect_pc("reset_ep", 8'h00, 1'b1, 8'h00);
    ep = 1'b0;

    // Release reset and load 8'h37 on the first edge.
    @(negedge clk);
    clr = 1'b1; lp = 1'b1; tb_en = 1'b1; tb_val = 8'h37;
    edge_settle();
    expect_pc("load_37", 8'h37, 1'b0, 8'h00);

    // Mid-cycle async reset clears q with no clock edge.
    @(negedge clk);
    lp = 1'b0; tb_en = 1'b0;
    #2;
    clr = 1'b0;
    #1;
    expect_pc("async_clr", 8'h00, 1'b1, 8'hFF);

    // lp/cp asserted while held in reset leave q at 0.
    lp = 1'b1; cp = 1'b1; tb_en = 1'b1; tb_val = 8'h55;
    edge_settle();
    expect_pc("rst_dom_1", 8'h00, 1'b0, 8'h00);
    edge_settle();
    expect_pc("rst_dom_2", 8'h00, 1'b0, 8'h00);

    // Count from 0 with the bus released.
    @(negedge clk);
    clr = 1'b1; lp = 1'b0; cp = 1'b1; tb_en = 1'b0;
    edge_settle();
    expect_pc("count_1", 8'h01, 1'b1, 8'hFF);
    edge_settle();
    expect_pc("count_2", 8'h02, 1'b1, 8'hFF);
    edge_settle();
    expect_pc("count_3", 8'h03, 1'b1, 8'hFF);
    @(negedge clk);
    cp = 1'b0; ep = 1'b1;
    #1;
    expect_pc("ep_on", 8'h03, 1'b1, 8'h03);
    ep = 1'b0;
    #1;
    expect_pc("ep_off", 8'h03, 1'b1, 8'hFF);

    // Wrap: FE -> FF -> 00.
    @(negedge clk);
    lp = 1'b1; tb_en = 1'b1; tb_val = 8'hFE;
    edge_settle();
    expect_pc("load_fe", 8'hFE, 1'b0, 8'h00);
    @(negedge clk);
    lp = 1'b0; tb_en = 1'b0; cp = 1'b1;
    edge_settle();
    expect_pc("wrap_ff", 8'hFF, 1'b0, 8'h00);
    edge_settle();
    expect_pc("wrap_00", 8'h00, 1'b0, 8'h00);

    // Load over count with ep=1: DUT must release the bus.
    @(negedge clk);
    lp = 1'b1; cp = 1'b1; ep = 1'b1; tb_en = 1'b1; tb_val = 8'hAA;
    #1;
    expect_pc("no_contend", 8'h00, 1'b1, 8'hAA);
    edge_settle();
    expect_pc("load_aa", 8'hAA, 1'b1, 8'hAA);

    // Load then count.
    @(negedge clk);
    lp = 1'b0; tb_en = 1'b0; ep = 1'b0; cp = 1'b1;
    edge_settle();
    expect_pc("count_ab", 8'hAB, 1'b1, 8'hFF);
    @(negedge clk);
    cp = 1'b0; ep = 1'b1;
    #1;
    expect_pc("ep_ab", 8'hAB, 1'b1, 8'hAB);

    // Hold for 5 edges while toggling ep.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ep = i[0];
      edge_settle();
      expect_pc($sformatf("hold_%0d", i), 8'hAB, 1'b1, i[0] ? 8'hAB : 8'hFF);
    end

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb.size() > 0; i++) #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_program_counter
